hitmem_comb_sched: RTL
======================

Name: hitmem_comb_sched

Overview:
Combination scheduler for a bank of NLAYERS hitmem instances, one per detector layer. After a road's hits are loaded, it walks every combination of one hit per layer in odometer order by driving the per-layer next and rewind strobes. It tags the resulting hitmem read data with valid/last flags for the downstream fitter, then clears the memories. Empty layers act as wildcards: their last is always high.

Parameters:
NLAYERS, 6, number of hitmem instances sequenced
RD_LAT, 2, cycles from a next/rewind strobe to the matching hitmem dout (loop register plus address register)
CNT_W, 16, width of the combination counter
MAX_COMB, 4096, combination cap; the walk is truncated once this count is reached

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse: all layers loaded, begin the walk; ignored while busy
abort  in  1  synchronous; terminate the walk and clear the memories
ready  in  1  downstream can accept one combination RD_LAT cycles later (credit style)
hm_last  in  NLAYERS  per-layer last flag (loop_last OR empty)
hm_empty  in  NLAYERS  per-layer empty flag
hm_next  out  NLAYERS  per-layer advance strobe
hm_rewind  out  NLAYERS  per-layer loop reset (rewind to position 0)
hm_clear  out  1  one-cycle clear to all memory counters
comb_valid  out  1  hitmem dout bus holds a valid combination this cycle
comb_last  out  1  qualifies the final combination of the road
comb_count  out  CNT_W  combinations issued in the current road
busy  out  1  walk in progress
done  out  1  one-cycle pulse at the end of a road
truncated  out  1  sticky: MAX_COMB was reached in this road; cleared on the next start

Behaviour:
- Reset: every output is 0; state is IDLE; the delay pipe is flushed.
- States: IDLE, REWIND, SETTLE, EMIT, DRAIN, CLEAR.
- IDLE: busy=0. start -> REWIND; comb_count and truncated are cleared.
- REWIND: hm_rewind = all ones for one cycle -> SETTLE.
- SETTLE: one-cycle wait for hm_last to reflect the new position.
  - If &hm_empty, go to CLEAR with no emission.
  - Otherwise -> EMIT.
- EMIT: hold while ready=0, with no strobes. When ready=1, issue one combination:
  - comb_count increments.
  - Let i be the lowest index with hm_last[i]=0.
    - If i exists and the new count < MAX_COMB: hm_next[i]=1, hm_rewind[j]=1 for all j<i, then -> SETTLE.
    - If all hm_last=1: mark the issue as last and go to DRAIN.
    - If the new count == MAX_COMB: mark the issue as last, set truncated, go to DRAIN.
  - hm_next and hm_rewind are never asserted in the same cycle for the same layer.
- Output pipe: the issue and last marks pass through an RD_LAT-stage shift register and appear as comb_valid/comb_last. Combinations are spaced at least 2 cycles apart because of SETTLE.
- DRAIN: wait RD_LAT cycles so the final combination exits the pipe -> CLEAR.
- CLEAR: hm_clear=1 and done=1 for one cycle -> IDLE.
- busy=1 in every state except IDLE.
- abort (any state except IDLE/CLEAR): next cycle is CLEAR; the pipe is flushed, so no comb_valid appears after abort is sampled; comb_count freezes.
- start while busy is ignored. abort and start together in IDLE: start wins.
- comb_count saturates at its maximum value; with the default parameters it never wraps.
- Async reset mid-walk: immediate return to IDLE with outputs 0. hm_clear is not issued, so the surrounding logic must also clear the memories.

Test Plan:
- Layer hit counts {2,1,1,1,1,3}, ready=1, start -> 6 combinations in order L0/L5 positions (0,0),(1,0),(0,1),(1,1),(0,2),(1,2); comb_valid 2 cycles after each issue; comb_last on the 6th; comb_count=6; then hm_clear and done.
- All layers empty, start -> no comb_valid, hm_clear and done 3 cycles after start (REWIND, SETTLE, CLEAR), comb_count=0.
- Layers 1 and 3 empty, others hold 2 hits each -> 16 combinations; hm_next[1] and hm_next[3] never asserted.
- Hit counts {2,2,1,1,1,1}, ready toggled 1,0,0,1 -> no strobe during ready=0; 4 combinations are still produced in order; the comb_valid gap matches the stall.
- MAX_COMB=4 with 3x3 hits -> exactly 4 comb_valid, comb_last on the 4th, truncated=1, done.
- abort after the 3rd issue -> no comb_valid afterwards, hm_clear the next cycle, comb_count=3. Separately, reset asserted in EMIT -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/hitmem_comb_sched.sv
// hitmem_comb_sched
// Walks every one-hit-per-layer combination of a loaded road across NLAYERS
// hitmem instances in odometer order (layer 0 fastest). It drives the
// per-layer next/rewind strobes, tags the hitmem read data with valid/last
// RD_LAT cycles later, and finally clears the memories. An empty layer
// always reports last, so it behaves as a wildcard that never advances.
//
// Ports
//   clock, reset          system clock, async active-high reset
//   start                 begin a walk (ignored while busy)
//   abort                 stop the walk, flush the output pipe, clear memories
//   ready                 downstream credit for one combination
//   hm_last, hm_empty     per-layer position/empty status from the hitmems
//   hm_next, hm_rewind    per-layer advance / rewind-to-0 strobes
//   hm_clear              one-cycle clear of all hitmem counters
//   comb_valid, comb_last qualifiers aligned with the hitmem dout bus
//   comb_count            combinations issued in the current road
//   busy, done            walk in progress / end-of-road pulse
//   truncated             sticky: the combination cap was hit this road
//
// state  | meaning
// IDLE   | waiting for start
// REWIND | rewind every layer to position 0
// SETTLE | let hm_last reflect the new positions
// EMIT   | wait for ready, then issue one combination and advance
// DRAIN  | let the final combination leave the output pipe
// CLEAR  | clear the memories and pulse done

module hitmem_comb_sched #(
   parameter int NLAYERS  = 6,
   parameter int RD_LAT   = 2,
   parameter int CNT_W    = 16,
   parameter int MAX_COMB = 4096
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   input  logic               abort,
   input  logic               ready,
   input  logic [NLAYERS-1:0] hm_last,
   input  logic [NLAYERS-1:0] hm_empty,
   output logic [NLAYERS-1:0] hm_next,
   output logic [NLAYERS-1:0] hm_rewind,
   output logic               hm_clear,
   output logic               comb_valid,
   output logic               comb_last,
   output logic [CNT_W-1:0]   comb_count,
   output logic               busy,
   output logic               done,
   output logic               truncated
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_REWIND = 3'd1;
   localparam logic [2:0] S_SETTLE = 3'd2;
   localparam logic [2:0] S_EMIT   = 3'd3;
   localparam logic [2:0] S_DRAIN  = 3'd4;
   localparam logic [2:0] S_CLEAR  = 3'd5;

   localparam int DRAIN_W = $clog2(RD_LAT + 1);
   // One extra bit so a cap equal to 2**CNT_W is still representable.
   localparam logic [CNT_W:0] CAP = (CNT_W + 1)'(MAX_COMB);

   logic [2:0]         state, state_nxt;
   logic [RD_LAT-1:0]  pipe_v, pipe_l;
   logic [DRAIN_W-1:0] drain_cnt;
   logic [NLAYERS-1:0] adv_sel, below_mask;
   logic [CNT_W-1:0]   count_inc;
   logic               adv_found, cap_hit, issue, issue_last, advance, kill;

   // Lowest layer whose last is low: isolate the lowest set bit of ~hm_last
   // (-(~x) == x + 1). Every layer below it wraps back to position 0.
   assign adv_sel    = ~hm_last & (hm_last + NLAYERS'(1));
   assign below_mask = adv_sel - NLAYERS'(1);
   assign adv_found  = |adv_sel;

   assign count_inc  = (&comb_count) ? comb_count : comb_count + CNT_W'(1);
   assign cap_hit    = {1'b0, count_inc} >= CAP;

   assign kill       = abort && (state != S_IDLE) && (state != S_CLEAR);
   assign issue      = (state == S_EMIT) && ready && !abort;
   assign advance    = issue && adv_found && !cap_hit;
   assign issue_last = issue && !advance;

   assign hm_next    = advance ? adv_sel : '0;
   assign hm_rewind  = (state == S_REWIND) ? '1 : (advance ? below_mask : '0);

   assign hm_clear   = (state == S_CLEAR);
   assign done       = (state == S_CLEAR);
   assign busy       = (state != S_IDLE);
   assign comb_valid = pipe_v[RD_LAT-1];
   assign comb_last  = pipe_l[RD_LAT-1];

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (start) state_nxt = S_REWIND;
         S_REWIND: state_nxt = S_SETTLE;
         S_SETTLE: state_nxt = (&hm_empty) ? S_CLEAR : S_EMIT;
         S_EMIT:   if (issue) state_nxt = issue_last ? S_DRAIN : S_SETTLE;
         S_DRAIN:  if (drain_cnt == '0) state_nxt = S_CLEAR;
         S_CLEAR:  state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
      if (kill) state_nxt = S_CLEAR;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= S_IDLE;
         pipe_v     <= '0;
         pipe_l     <= '0;
         drain_cnt  <= '0;
         comb_count <= '0;
         truncated  <= 1'b0;
      end else begin
         state <= state_nxt;

         // Abort drops anything still in flight so nothing valid follows it.
         if (kill) begin
            pipe_v <= '0;
            pipe_l <= '0;
         end else begin
            pipe_v <= (pipe_v << 1) | RD_LAT'(issue);
            pipe_l <= (pipe_l << 1) | RD_LAT'(issue_last);
         end

         if (state == S_IDLE && start) begin
            comb_count <= '0;
            truncated  <= 1'b0;
         end else if (issue) begin
            comb_count <= count_inc;
            if (cap_hit) truncated <= 1'b1;
         end

         if (issue_last)
            drain_cnt <= DRAIN_W'(RD_LAT - 1);
         else if (state == S_DRAIN && drain_cnt != '0)
            drain_cnt <= drain_cnt - DRAIN_W'(1);
      end
   end

endmodule
